// File: rtl/stage_wb.sv
// Writeback stage: commits register writes, redirects, TLB writes and exceptions,
// and drains committed stores to the D-cache through an in-order store buffer.
package common;
  localparam int n_threads = 4;
  typedef logic [$clog2(n_threads)-1:0] threadid_t;
  typedef logic [4:0]  regid_t;
  typedef logic [31:0] word_t;
  typedef logic [31:0] vptr_t;
  typedef logic [31:0] pptr_t;
  typedef logic [19:0] vpn_t;
  typedef logic [19:0] ppn_t;
  typedef enum logic [1:0] {TLBW_NONE = 2'd0, TLBW_ITLB = 2'd1, TLBW_DTLB = 2'd2} tlbwrite_t;
endpackage

module stage_wb
  import common::*;
#(
  parameter int SB_DEPTH  = 4,
  parameter int N_THREADS = common::n_threads
) (
  input  logic                     clk,
  input  logic                     rst,
  input  threadid_t                wb_thread,
  input  logic                     wb_isvalid,
  input  logic                     wb_itlb_miss,
  input  logic                     wb_dtlb_miss,
  input  regid_t                   wb_dst,
  input  vptr_t                    wb_pc,
  input  word_t                    wb_r2,
  input  word_t                    wb_data,
  input  word_t                    wb_mul,
  input  logic                     wb_isequal,
  input  logic                     wb_flag_mul,
  input  logic                     wb_flag_reg,
  input  logic                     wb_flag_jump,
  input  logic                     wb_flag_branch,
  input  logic                     wb_flag_iret,
  input  logic                     wb_flag_store,
  input  logic                     wb_flag_isbyte,
  input  tlbwrite_t                wb_flag_tlbwrite,
  input  pptr_t                    wb_paddr,
  output logic                     rf_wen,
  output threadid_t                rf_thread,
  output regid_t                   rf_dst,
  output word_t                    rf_data,
  output logic                     redirect_en,
  output threadid_t                redirect_thread,
  output vptr_t                    redirect_pc,
  output logic                     exc_en,
  output threadid_t                exc_thread,
  output logic                     itlbwrite_en,
  output logic                     dtlbwrite_en,
  output vpn_t                     tlbwrite_vpn,
  output ppn_t                     tlbwrite_ppn,
  output word_t [N_THREADS-1:0]    rm0,
  output word_t [N_THREADS-1:0]    rm1,
  output word_t [N_THREADS-1:0]    rm2,
  output word_t [N_THREADS-1:0]    rm4,
  output logic                     store_en,
  output logic                     store_isbyte,
  output pptr_t                    store_addr,
  output word_t                    store_data,
  input  pptr_t                    probe_addr,
  output logic                     probe_hit,
  output logic                     sb_full,
  output logic                     replay_en,
  output threadid_t                replay_thread
);
  localparam int IDX_W = $clog2(SB_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  pptr_t            sb_addr_mem   [SB_DEPTH];
  word_t            sb_data_mem   [SB_DEPTH];
  logic             sb_isbyte_mem [SB_DEPTH];
  logic [PTR_W-1:0] wptr_reg, rptr_reg, occupancy, occupancy_next;
  logic             sb_full_reg;
  pptr_t            last_addr_reg;
  word_t            last_data_reg;
  logic             last_isbyte_reg;
  logic             exc_any, commit, push, pop;
  logic [SB_DEPTH-1:0] hit_vec;
  logic             unused_probe_lsb;

  assign occupancy = wptr_reg - rptr_reg;
  assign pop       = (occupancy != '0);
  assign sb_full   = sb_full_reg;

  assign exc_any = wb_itlb_miss | wb_dtlb_miss;
  assign commit  = wb_isvalid & ~exc_any & ~(wb_flag_store & sb_full_reg & ~pop);
  assign push    = commit & wb_flag_store;

  assign rf_wen    = commit & wb_flag_reg;
  assign rf_data   = wb_flag_mul ? wb_mul : wb_data;
  assign rf_thread = wb_thread;
  assign rf_dst    = wb_dst;

  assign redirect_en     = commit & (wb_flag_jump | (wb_flag_branch & wb_isequal) | wb_flag_iret);
  assign redirect_thread = wb_thread;
  assign redirect_pc     = wb_flag_iret ? rm0[wb_thread] : wb_data;

  assign exc_en     = wb_isvalid & exc_any;
  assign exc_thread = wb_thread;

  assign itlbwrite_en = commit & (wb_flag_tlbwrite == TLBW_ITLB);
  assign dtlbwrite_en = commit & (wb_flag_tlbwrite == TLBW_DTLB);
  assign tlbwrite_vpn = wb_data[31:12];
  assign tlbwrite_ppn = wb_r2[31:12];

  // Unreachable while the drain is unconditional, but kept so a stalled drain stays safe.
  assign replay_en     = wb_isvalid & ~exc_any & wb_flag_store & sb_full_reg & ~pop;
  assign replay_thread = wb_thread;

  // Head is presented combinationally; when idle the last presented store is held.
  assign store_en     = pop;
  assign store_addr   = pop ? sb_addr_mem[rptr_reg[IDX_W-1:0]]   : last_addr_reg;
  assign store_data   = pop ? sb_data_mem[rptr_reg[IDX_W-1:0]]   : last_data_reg;
  assign store_isbyte = pop ? sb_isbyte_mem[rptr_reg[IDX_W-1:0]] : last_isbyte_reg;

  assign occupancy_next = occupancy + PTR_W'(push) - PTR_W'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr_mem[wptr_reg[IDX_W-1:0]]   <= wb_paddr;
      sb_data_mem[wptr_reg[IDX_W-1:0]]   <= wb_r2;
      sb_isbyte_mem[wptr_reg[IDX_W-1:0]] <= wb_flag_isbyte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      sb_full_reg     <= 1'b0;
      last_addr_reg   <= '0;
      last_data_reg   <= '0;
      last_isbyte_reg <= 1'b0;
    end else begin
      wptr_reg    <= wptr_reg + PTR_W'(push);
      rptr_reg    <= rptr_reg + PTR_W'(pop);
      sb_full_reg <= (occupancy_next == PTR_W'(SB_DEPTH));
      if (pop) begin
        last_addr_reg   <= store_addr;
        last_data_reg   <= store_data;
        last_isbyte_reg <= store_isbyte;
      end
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_probe
    logic [IDX_W-1:0] rel;
    assign rel         = IDX_W'(gi) - rptr_reg[IDX_W-1:0];
    assign hit_vec[gi] = ({1'b0, rel} < occupancy) &&
                         (sb_addr_mem[gi][31:2] == probe_addr[31:2]);
  end
  assign probe_hit        = |hit_vec;
  assign unused_probe_lsb = ^probe_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_THREADS; i++) begin
        rm0[i] <= '0;
        rm1[i] <= '0;
        rm2[i] <= '0;
        rm4[i] <= 32'd1;
      end
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (exc_en && wb_thread == threadid_t'(i)) begin
          rm0[i] <= wb_pc;
          rm1[i] <= wb_itlb_miss ? wb_pc : wb_data;
          rm2[i] <= wb_itlb_miss ? 32'd0 : 32'd1;
          rm4[i] <= 32'd1;
        end else if (commit && wb_flag_iret && wb_thread == threadid_t'(i)) begin
          rm4[i] <= 32'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_stage_wb.sv
// Directed bench for stage_wb: writeback, redirect, exceptions, TLB write, store drain, probe, reset.
module tb_stage_wb;
  import common::*;

  logic clk, rst;
  threadid_t wb_thread;
  logic wb_isvalid, wb_itlb_miss, wb_dtlb_miss;
  regid_t wb_dst;
  vptr_t wb_pc;
  word_t wb_r2, wb_data, wb_mul;
  logic wb_isequal, wb_flag_mul, wb_flag_reg, wb_flag_jump, wb_flag_branch;
  logic wb_flag_iret, wb_flag_store, wb_flag_isbyte;
  tlbwrite_t wb_flag_tlbwrite;
  pptr_t wb_paddr, probe_addr;
  logic rf_wen, redirect_en, exc_en, itlbwrite_en, dtlbwrite_en;
  threadid_t rf_thread, redirect_thread, exc_thread, replay_thread;
  regid_t rf_dst;
  word_t rf_data, store_data;
  vptr_t redirect_pc;
  vpn_t tlbwrite_vpn;
  ppn_t tlbwrite_ppn;
  word_t [n_threads-1:0] rm0, rm1, rm2, rm4;
  logic store_en, store_isbyte, probe_hit, sb_full, replay_en;
  pptr_t store_addr;

  int checks = 0;
  int errors = 0;

  stage_wb dut (
    .clk(clk), .rst(rst), .wb_thread(wb_thread), .wb_isvalid(wb_isvalid),
    .wb_itlb_miss(wb_itlb_miss), .wb_dtlb_miss(wb_dtlb_miss), .wb_dst(wb_dst),
    .wb_pc(wb_pc), .wb_r2(wb_r2), .wb_data(wb_data), .wb_mul(wb_mul),
    .wb_isequal(wb_isequal), .wb_flag_mul(wb_flag_mul), .wb_flag_reg(wb_flag_reg),
    .wb_flag_jump(wb_flag_jump), .wb_flag_branch(wb_flag_branch),
    .wb_flag_iret(wb_flag_iret), .wb_flag_store(wb_flag_store),
    .wb_flag_isbyte(wb_flag_isbyte), .wb_flag_tlbwrite(wb_flag_tlbwrite),
    .wb_paddr(wb_paddr), .rf_wen(rf_wen), .rf_thread(rf_thread), .rf_dst(rf_dst),
    .rf_data(rf_data), .redirect_en(redirect_en), .redirect_thread(redirect_thread),
    .redirect_pc(redirect_pc), .exc_en(exc_en), .exc_thread(exc_thread),
    .itlbwrite_en(itlbwrite_en), .dtlbwrite_en(dtlbwrite_en),
    .tlbwrite_vpn(tlbwrite_vpn), .tlbwrite_ppn(tlbwrite_ppn),
    .rm0(rm0), .rm1(rm1), .rm2(rm2), .rm4(rm4),
    .store_en(store_en), .store_isbyte(store_isbyte), .store_addr(store_addr),
    .store_data(store_data), .probe_addr(probe_addr), .probe_hit(probe_hit),
    .sb_full(sb_full), .replay_en(replay_en), .replay_thread(replay_thread)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    wb_thread = '0; wb_isvalid = 0; wb_itlb_miss = 0; wb_dtlb_miss = 0;
    wb_dst = '0; wb_pc = '0; wb_r2 = '0; wb_data = '0; wb_mul = '0;
    wb_isequal = 0; wb_flag_mul = 0; wb_flag_reg = 0; wb_flag_jump = 0;
    wb_flag_branch = 0; wb_flag_iret = 0; wb_flag_store = 0; wb_flag_isbyte = 0;
    wb_flag_tlbwrite = TLBW_NONE; wb_paddr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 0; rst = 1; probe_addr = '0;
    clear_in();
    #2;
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_store_en", store_en, 0);
    chk("reset_probe_hit", probe_hit, 0);
    chk("reset_sb_full", sb_full, 0);
    chk("reset_rm4_0", rm4[0], 1);
    chk("reset_rm4_3", rm4[3], 1);
    chk("reset_rm0_1", rm0[1], 0);
    chk("reset_redirect", redirect_en, 0);
    chk("reset_exc", exc_en, 0);
    next_cycle();
    rst = 0;

    // ALU and multiplier writeback
    wb_isvalid = 1; wb_flag_reg = 1; wb_data = 32'h1234; wb_dst = 5'd5; #1;
    $display("txn alu writeback");
    chk("alu_rf_wen", rf_wen, 1);
    chk("alu_rf_data", rf_data, 32'h1234);
    chk("alu_rf_dst", rf_dst, 5);
    chk("alu_no_redirect", redirect_en, 0);
    wb_flag_mul = 1; wb_mul = 32'hBEEF; #1;
    $display("txn mul writeback");
    chk("mul_rf_data", rf_data, 32'hBEEF);
    chk("mul_rf_wen", rf_wen, 1);

    // Branch taken / not taken
    next_cycle(); clear_in();
    wb_isvalid = 1; wb_flag_branch = 1; wb_isequal = 1; wb_data = 32'h2000; #1;
    $display("txn branch taken");
    chk("br_taken_en", redirect_en, 1);
    chk("br_taken_pc", redirect_pc, 32'h2000);
    wb_isequal = 0; #1;
    $display("txn branch not taken");
    chk("br_nt_en", redirect_en, 0);

    // Invalid instruction has no side effects
    clear_in(); wb_flag_reg = 1; wb_flag_jump = 1; wb_dtlb_miss = 1; #1;
    $display("txn invalid");
    chk("inv_rf_wen", rf_wen, 0);
    chk("inv_redirect", redirect_en, 0);
    chk("inv_exc", exc_en, 0);

    // DTLB write
    clear_in(); wb_isvalid = 1; wb_flag_tlbwrite = TLBW_DTLB;
    wb_data = 32'hABCDE123; wb_r2 = 32'h12345678; #1;
    $display("txn dtlb write");
    chk("tlbw_dtlb_en", dtlbwrite_en, 1);
    chk("tlbw_itlb_en", itlbwrite_en, 0);
    chk("tlbw_vpn", tlbwrite_vpn, 20'hABCDE);
    chk("tlbw_ppn", tlbwrite_ppn, 20'h12345);

    // DTLB miss on thread 1
    next_cycle(); clear_in();
    wb_isvalid = 1; wb_thread = 2'd1; wb_pc = 32'h1000; wb_data = 32'h8000;
    wb_dtlb_miss = 1; wb_flag_reg = 1; wb_flag_jump = 1; #1;
    $display("txn dtlb miss t1");
    chk("dmiss_exc_en", exc_en, 1);
    chk("dmiss_exc_thread", exc_thread, 1);
    chk("dmiss_rf_wen", rf_wen, 0);
    chk("dmiss_redirect", redirect_en, 0);
    next_cycle();
    chk("dmiss_rm0", rm0[1], 32'h1000);
    chk("dmiss_rm1", rm1[1], 32'h8000);
    chk("dmiss_rm2", rm2[1], 1);
    chk("dmiss_rm4", rm4[1], 1);
    chk("dmiss_rm0_other", rm0[0], 0);

    // Iret on thread 1
    clear_in(); wb_isvalid = 1; wb_thread = 2'd1; wb_flag_iret = 1; wb_data = 32'h5555; #1;
    $display("txn iret t1");
    chk("iret_en", redirect_en, 1);
    chk("iret_pc", redirect_pc, 32'h1000);
    chk("iret_thread", redirect_thread, 1);
    next_cycle();
    chk("iret_rm4_1", rm4[1], 0);
    chk("iret_rm4_0", rm4[0], 1);

    // Both misses on thread 2: ITLB wins
    clear_in(); wb_isvalid = 1; wb_thread = 2'd2; wb_pc = 32'h3000; wb_data = 32'h9000;
    wb_itlb_miss = 1; wb_dtlb_miss = 1; #1;
    $display("txn itlb miss t2");
    chk("imiss_exc_en", exc_en, 1);
    next_cycle();
    chk("imiss_rm1", rm1[2], 32'h3000);
    chk("imiss_rm2", rm2[2], 0);
    chk("imiss_rm0", rm0[2], 32'h3000);

    // Store drain: A then B back to back
    clear_in(); wb_isvalid = 1; wb_flag_store = 1; wb_paddr = 32'h40;
    wb_r2 = 32'h11; wb_flag_isbyte = 1; #1;
    $display("txn store A push");
    chk("stA_empty_store_en", store_en, 0);
    chk("stA_replay", replay_en, 0);
    next_cycle();
    wb_paddr = 32'h44; wb_r2 = 32'h22; wb_flag_isbyte = 0; probe_addr = 32'h42; #1;
    $display("txn store A drain, B push");
    chk("drainA_en", store_en, 1);
    chk("drainA_addr", store_addr, 32'h40);
    chk("drainA_data", store_data, 32'h11);
    chk("drainA_isbyte", store_isbyte, 1);
    chk("probe_42_hit", probe_hit, 1);
    probe_addr = 32'h48; #1;
    chk("probe_48_miss", probe_hit, 0);
    next_cycle(); clear_in();
    $display("txn store B drain");
    chk("drainB_en", store_en, 1);
    chk("drainB_addr", store_addr, 32'h44);
    chk("drainB_data", store_data, 32'h22);
    chk("drainB_isbyte", store_isbyte, 0);
    next_cycle();
    probe_addr = 32'h40; #1;
    $display("txn drained");
    chk("drained_en", store_en, 0);
    chk("drained_hold_addr", store_addr, 32'h44);
    chk("drained_probe_40", probe_hit, 0);
    chk("drained_sb_full", sb_full, 0);

    // Reset mid-drain discards buffered store
    wb_isvalid = 1; wb_flag_store = 1; wb_paddr = 32'h80; wb_r2 = 32'h33;
    next_cycle(); clear_in();
    probe_addr = 32'h80; #1;
    $display("txn store C pending");
    chk("stC_en", store_en, 1);
    chk("stC_probe", probe_hit, 1);
    rst = 1; #1;
    $display("txn reset mid drain");
    chk("rst_store_en", store_en, 0);
    chk("rst_probe", probe_hit, 0);
    chk("rst_rm4_1", rm4[1], 1);
    chk("rst_rm0_1", rm0[1], 0);
    chk("rst_store_addr", store_addr, 0);
    next_cycle();
    rst = 0;
    next_cycle();
    $display("txn after reset");
    chk("post_rst_store_en", store_en, 0);
    chk("post_rst_probe", probe_hit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
